// File: rtl/sap_controller.sv
// sap_controller
//   Controller-sequencer for the 8-bit bus machine. A six-state one-hot ring
//   counter (T1..T6) together with the instruction register's opcode nibble
//   is decoded into the control word for every register stage.
//   The machine supports LDA, ADD, SUB, OUT and HLT.
//
// Ports
//   clk    : system clock, all state changes on the rising edge
//   clr    : asynchronous active-low reset
//   opcode : upper nibble of the instruction register; it must be held
//            stable from the end of T3 through T6 because it is not latched
//   t      : one-hot ring state, t[0]=T1 .. t[5]=T6
//   cp, ep : program counter increment / bus enable (active high)
//   lm, ce : MAR load / memory bus enable (active low)
//   li, ei : IR load / IR operand bus enable (active low)
//   la, ea : accumulator load (active low) / bus enable (active high)
//   su, eu : adder/subtractor mode (1 = subtract) / bus enable (active high)
//   lb, lo : B register load / output register load (active low)
//   halt   : machine halted (active high)
module sap_controller #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] opcode,
   output logic [5:0] t,
   output logic       cp,
   output logic       ep,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb,
   output logic       lo,
   output logic       halt
);

   // The state encoding is the one-hot ring itself, so t is the raw state.
   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } state_e;

   state_e state_q, state_d;
   logic   halted_q, halted_d;

   // Next-state logic. Once halted, the ring freezes at T4 until clr.
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (state_q == T4 && opcode == OP_HLT) begin
            halted_d = 1'b1;
         end else begin
            case (state_q)
               T1:      state_d = T2;
               T2:      state_d = T3;
               T3:      state_d = T4;
               T4:      state_d = T5;
               T5:      state_d = T6;
               T6:      state_d = T1;
               default: state_d = T1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= T1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign t = state_q;

   // Control decode. Everything starts at the idle word; the decode is gated
   // by clr so that holding reset low yields the idle word even though the
   // ring sits at T1, and by the halted flag so opcode changes are ignored.
   always_comb begin
      cp = 1'b0;
      ep = 1'b0;
      lm = 1'b1;
      ce = 1'b1;
      li = 1'b1;
      ei = 1'b1;
      la = 1'b1;
      ea = 1'b0;
      su = 1'b0;
      eu = 1'b0;
      lb = 1'b1;
      lo = 1'b1;
      if (clr && !halted_q) begin
         case (state_q)
            T1: begin
               ep = 1'b1;
               lm = 1'b0;
            end
            T2: cp = 1'b1;
            T3: begin
               ce = 1'b0;
               li = 1'b0;
            end
            T4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  ei = 1'b0;
                  lm = 1'b0;
               end else if (opcode == OP_OUT) begin
                  ea = 1'b1;
                  lo = 1'b0;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  ce = 1'b0;
                  la = 1'b0;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  ce = 1'b0;
                  lb = 1'b0;
               end
            end
            T6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  eu = 1'b1;
                  la = 1'b0;
                  su = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   // HLT asserts halt combinationally in T4, then the flag holds it.
   assign halt = clr & (halted_q | (state_q == T4 && opcode == OP_HLT));

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller
//   Self-checking bench for sap_controller: a table of per-cycle vectors for
//   the LDA/ADD/SUB/OUT/undefined instruction cycles, plus hand-written
//   sequences for reset, halt and reset mid-instruction.
//   Control word packing: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}.
module tb_sap_controller;

   localparam logic [11:0] W_IDLE = 12'b001111100011;
   localparam logic [11:0] W_T1   = 12'b010111100011;
   localparam logic [11:0] W_T2   = 12'b101111100011;
   localparam logic [11:0] W_T3   = 12'b001001100011;
   localparam logic [11:0] W_T4M  = 12'b000110100011; // ei=0 lm=0
   localparam logic [11:0] W_T5L  = 12'b001011000011; // ce=0 la=0
   localparam logic [11:0] W_T5B  = 12'b001011100001; // ce=0 lb=0
   localparam logic [11:0] W_T6A  = 12'b001111000111; // eu=1 su=0 la=0
   localparam logic [11:0] W_T6S  = 12'b001111001111; // eu=1 su=1 la=0
   localparam logic [11:0] W_T4O  = 12'b001111110010; // ea=1 lo=0

   typedef struct {
      logic [3:0]  opcode;
      logic [5:0]  t;
      logic [11:0] word;
      logic        halt;
   } vec_t;

   localparam int NV = 31;

   logic       clk;
   logic       clr;
   logic [3:0] opcode;
   logic [5:0] t;
   logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt;

   int errors;
   int checks;
   vec_t vecs [NV];

   sap_controller dut (
      .clk(clk), .clr(clr), .opcode(opcode), .t(t),
      .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
      .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .halt(halt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] word_now();
      return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic [5:0] et,
                              input logic [11:0] ew, input logic eh);
      int drivers;
      check({name, ".t"}, {10'd0, t}, {10'd0, et});
      check({name, ".word"}, {4'd0, word_now()}, {4'd0, ew});
      check({name, ".halt"}, {15'd0, halt}, {15'd0, eh});
      drivers = int'(ep) + int'(!ce) + int'(!ei) + int'(ea) + int'(eu);
      check({name, ".bus_ok"}, {15'd0, drivers <= 1}, 16'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_group(input int base, input logic [3:0] op,
                            input logic [11:0] w4, input logic [11:0] w5,
                            input logic [11:0] w6);
      vecs[base+0] = '{op, 6'b000001, W_T1, 1'b0};
      vecs[base+1] = '{op, 6'b000010, W_T2, 1'b0};
      vecs[base+2] = '{op, 6'b000100, W_T3, 1'b0};
      vecs[base+3] = '{op, 6'b001000, w4,   1'b0};
      vecs[base+4] = '{op, 6'b010000, w5,   1'b0};
      vecs[base+5] = '{op, 6'b100000, w6,   1'b0};
   endtask

   initial begin
      errors = 0;
      checks = 0;

      set_group(0,  4'h0, W_T4M,  W_T5L,  W_IDLE); // LDA
      set_group(6,  4'h1, W_T4M,  W_T5B,  W_T6A);  // ADD
      set_group(12, 4'h2, W_T4M,  W_T5B,  W_T6S);  // SUB
      set_group(18, 4'hE, W_T4O,  W_IDLE, W_IDLE); // OUT
      set_group(24, 4'h7, W_IDLE, W_IDLE, W_IDLE); // undefined
      vecs[30] = '{4'h0, 6'b000001, W_T1, 1'b0};   // ring wraps

      // reset held for 3 clocks
      clr = 1'b0;
      opcode = 4'h1;
      #2;
      repeat (3) step();
      check_state("reset", 6'b000001, W_IDLE, 1'b0);

      // release away from an edge: T1 decodes before the first edge
      #2;
      clr = 1'b1;
      #1;
      check_state("rel_t1", 6'b000001, W_T1, 1'b0);
      step();
      check_state("rel_t2", 6'b000010, W_T2, 1'b0);
      repeat (5) step();

      // table-driven instruction cycles, starting at T1
      for (int i = 0; i < NV; i++) begin
         opcode = vecs[i].opcode;
         #1;
         check_state($sformatf("vec%0d", i), vecs[i].t, vecs[i].word, vecs[i].halt);
         step();
      end
      // vector 30 was T1, so the ring is now at T2; finish that cycle
      repeat (5) step();

      // HLT: halt in T4 combinationally, then frozen at T4
      opcode = 4'hF;
      #1;
      check_state("hlt_t1", 6'b000001, W_T1, 1'b0);
      repeat (3) step();
      check_state("hlt_t4", 6'b001000, W_IDLE, 1'b1);
      step();
      opcode = 4'h0;
      repeat (10) step();
      check_state("halted", 6'b001000, W_IDLE, 1'b1);
      opcode = 4'h1;
      #1;
      check_state("halted_op", 6'b001000, W_IDLE, 1'b1);

      // clr pulse exits halt and fetch resumes
      #2;
      clr = 1'b0;
      #1;
      check_state("hlt_clr", 6'b000001, W_IDLE, 1'b0);
      #2;
      clr = 1'b1;
      #1;
      check_state("hlt_resume", 6'b000001, W_T1, 1'b0);
      step();
      check_state("hlt_resume_t2", 6'b000010, W_T2, 1'b0);
      repeat (5) step();

      // reset mid-T5 of an ADD
      opcode = 4'h1;
      repeat (4) step();
      check_state("add_t5", 6'b010000, W_T5B, 1'b0);
      clr = 1'b0;
      #1;
      check_state("mid_clr", 6'b000001, W_IDLE, 1'b0);
      step();
      check_state("mid_clr_hold", 6'b000001, W_IDLE, 1'b0);
      #2;
      clr = 1'b1;
      #1;
      check_state("mid_rel", 6'b000001, W_T1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Controller-sequencer for the 8-bit bus machine.
- Generates the control word that drives every register stage, including the accumulator's active-low load (la) and active-high bus enable (ea), from a 6-state ring counter and the 4-bit opcode held in the instruction register.
- Sits directly upstream of the accumulator, adder/subtractor, B register, memory address register, program counter, instruction register and output register.
- Supports LDA, ADD, SUB, OUT and HLT.

Parameters:
- OP_LDA, 4'h0, opcode for load accumulator from memory
- OP_ADD, 4'h1, opcode for add memory operand to accumulator
- OP_SUB, 4'h2, opcode for subtract memory operand from accumulator
- OP_OUT, 4'hE, opcode for copy accumulator to output register
- OP_HLT, 4'hF, opcode for halt sequencing

Ports:
- clk  input  1  system clock; all state changes on rising edge
- clr  input  1  asynchronous active-low reset
- opcode  input  4  upper nibble of instruction register
- t  output  6  one-hot ring state, t[0]=T1 .. t[5]=T6
- cp  output  1  program counter increment, active high
- ep  output  1  program counter drives bus, active high
- lm  output  1  memory address register load, active low
- ce  output  1  memory drives bus, active low
- li  output  1  instruction register load, active low
- ei  output  1  instruction register operand nibble drives bus, active low
- la  output  1  accumulator load, active low
- ea  output  1  accumulator drives bus, active high
- su  output  1  adder/subtractor mode: 0 add, 1 subtract
- eu  output  1  adder/subtractor drives bus, active high
- lb  output  1  B register load, active low
- lo  output  1  output register load, active low
- halt  output  1  machine halted, active high

Behaviour:
- Idle word: cp=0 ep=0 lm=1 ce=1 li=1 ei=1 la=1 ea=0 su=0 eu=0 lb=1 lo=1.
- Reset:
  - clr=0 asynchronously forces t=6'b000001, clears the halted flag and forces all control outputs to the idle word, regardless of clk.
  - After clr rises, outputs decode T1 immediately.
- Ring counter:
  - One-hot. Advances T1->T2->T3->T4->T5->T6->T1 on each rising clk.
  - Exactly one bit of t is set at all times.
- Control outputs are combinational decode of t and opcode. Any signal not listed for a state takes its idle value.
- Fetch (all opcodes):
  - T1: ep=1, lm=0.
  - T2: cp=1.
  - T3: ce=0, li=0.
  - opcode is don't-care in T1-T3.
- Execute, with opcode decoded in T4-T6 only:
  - LDA: T4 ei=0, lm=0; T5 ce=0, la=0; T6 idle.
  - ADD: T4 ei=0, lm=0; T5 ce=0, lb=0; T6 eu=1, su=0, la=0.
  - SUB: same as ADD except su=1 in T6.
  - OUT: T4 ea=1, lo=0; T5 idle; T6 idle.
  - HLT:
    - T4 drives the idle word and halt=1 combinationally.
    - At the rising edge ending T4, the halted flag sets and the ring counter holds at T4.
    - While halted: t stays 6'b001000, all outputs stay idle, halt=1, and opcode changes are ignored.
    - Only clr exits halt.
  - Undefined opcodes: T4-T6 idle, no halt, sequencing continues.
- Bus safety: at most one bus driver (ep, ce=0, ei=0, ea, eu) is active in any state.
- Opcode must be stable from the end of T3 through T6; the block does not latch it.
- Latency: one instruction = 6 clocks; ADD/SUB result is loaded into the accumulator at the rising edge ending T6.
- Reset mid-instruction: ring returns to T1 at once; no partial control word persists.

Test Plan:
- Reset: hold clr=0 for 3 clocks with opcode=4'h1 -> t=6'b000001, idle word, halt=0; release clr -> ep=1, lm=0 before the first edge.
- LDA: opcode=4'h0 for 6 clocks -> t walks 000001..100000; observe T1 ep=1/lm=0, T2 cp=1, T3 ce=0/li=0, T4 ei=0/lm=0, T5 ce=0/la=0, T6 idle; back to T1 on the 7th edge.
- ADD vs SUB: opcode=4'h1 -> T5 ce=0/lb=0, T6 eu=1/su=0/la=0; then opcode=4'h2 -> T6 eu=1/su=1/la=0; check one bus driver per state.
- OUT: opcode=4'hE -> T4 ea=1/lo=0, all other states after fetch idle.
- HLT: opcode=4'hF -> halt=1 in T4; after 10 more clocks t=6'b001000, halt=1, outputs idle, even with opcode changed to 4'h0; pulse clr=0 -> t=6'b000001, halt=0, fetch resumes.
- Undefined opcode 4'h7: T4-T6 idle, halt=0, ring wraps. Also assert clr=0 mid-T5 of an ADD -> outputs idle immediately, t=T1.
